seg_scan_display: RTL and testbench
===================================

Name: seg_scan_display

Overview:
Parametrised multiplexed seven-segment display driver for the CPU board top level.
- Captures a packed hex word (e.g. LED_num) into a shadow register.
- Time-multiplexes DIGITS digits onto a shared SEG bus with one-hot active-low AN enables.
- Adds a configurable scan rate, a per-digit blank mask, decimal points, and a freeze input so the display holds its value while the CPU is halted.

Parameters:
- DIGITS, 8, number of digits scanned; legal range 1..16.
- CLK_DIV, 16, CLK cycles per digit slot; legal range >=1.
- DIV_W, 16, width of the divider counter; must satisfy 2**DIV_W >= CLK_DIV.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-low (0 = reset).
- data  in  4*DIGITS  packed hex nibbles; digit i = data[4i+3:4i].
- load  in  1  capture data into the shadow register this cycle.
- freeze  in  1  hold the shadow register (typically tied to halt).
- dp  in  DIGITS  decimal-point request per digit, active-high.
- blank_mask  in  DIGITS  1 = force digit i dark.
- SEG  out  8  active-low segments: SEG[0]=a … SEG[6]=g, SEG[7]=dp.
- AN  out  DIGITS  active-low one-hot digit enable.
- scan_idx  out  4  index of the digit currently shown on SEG/AN.

Behaviour:
- Reset (RST=0, asynchronous):
  - shadow=0, div_cnt=0, idx=0.
  - SEG=8'hFF, AN=all ones, scan_idx=0.
  - Takes effect immediately, including mid-scan or mid-load.
- Shadow register:
  - On an edge with load=1 and freeze=0, shadow <= data.
  - freeze=1 blocks the update; shadow holds its value.
  - dp and blank_mask are not shadowed; they are sampled live.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps to 0.
  - tick is asserted when div_cnt==CLK_DIV-1.
  - With CLK_DIV=1, tick is asserted every cycle.
- Index:
  - On tick, idx <= (idx==DIGITS-1) ? 0 : idx+1.
  - With DIGITS=1, idx stays 0.
  - idx never exceeds DIGITS-1.
- Output registers (one-cycle latency from idx/shadow/dp/blank_mask):
  - AN <= ~(1<<idx).
  - scan_idx <= idx.
  - SEG[6:0] <= decode(shadow nibble idx). SEG[7] <= ~dp[idx].
  - If blank_mask[idx]=1: SEG <= 8'hFF, and AN still selects the digit.
- Decode table (SEG[7:0] with dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
- Simultaneous load and tick: both take effect on the same edge; the next output reflects the new shadow at the new idx.
- After reset release:
  - first edge: outputs show digit 0 (AN[0]=0).
  - every CLK_DIV edges thereafter: advance to the next digit.
- Exactly one AN bit is 0 at all times outside reset.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: digit i>0 is blanked (SEG=8'hFF, dp also suppressed) when shadow nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked by this rule. blank_mask is ORed with the rule.
- Undefined: no automatic blanking; only blank_mask blanks digits.

Test Plan:
1. Reset values: RST=0 with CLK running -> SEG=8'hFF, AN=8'hFF, scan_idx=0; asserting RST low mid-scan clears outputs without waiting for a clock edge.
2. Scan order (DIGITS=4, CLK_DIV=4): after release, AN sequence 1110,1101,1011,0111,1110… with each value held exactly 4 cycles.
3. Decode (DIGITS=8): load=1 with data=32'h89AB_CDEF -> SEG at idx0..7 = 8E,86,A1,C6,83,88,90,80; dp[2]=1 -> SEG at idx2 = 8'h21.
4. Freeze: load 32'h1234_5678, then freeze=1 with load=1 and data=32'hFFFF_FFFF -> display still shows 8,7,6,5,4,3,2,1; after freeze=0 and load=1, all digits show F (8E).
5. Blanking: blank_mask=8'h0F -> digits 0..3 SEG=8'hFF while AN still cycles. With SEG_LEADING_ZERO_BLANK_EN and data=32'h0000_0A05 -> digits 0..2 show 92,C0,88 and digits 3..7 show FF.
6. Edge configuration (CLK_DIV=1, DIGITS=1): AN stays 1'b0; load of a new nibble appears on SEG exactly one cycle later.

Source files
------------

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment driver: shadows a hex word, scans DIGITS digits with one-hot active-low AN.
// Outputs are registered one cycle after idx/shadow/dp/blank_mask. No backpressure; freeze holds the shadow.
// Optional SEG_LEADING_ZERO_BLANK_EN darkens digits above the most significant non-zero nibble.
module seg_scan_display #(
    parameter int DIGITS  = 8,
    parameter int CLK_DIV = 16,
    parameter int DIV_W   = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [4*DIGITS-1:0]   data,
    input  logic                  load,
    input  logic                  freeze,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank_mask,
    output logic [7:0]            SEG,
    output logic [DIGITS-1:0]     AN,
    output logic [3:0]            scan_idx
);

    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [3:0]          idx_q, idx_d;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [3:0]          sidx_q;

    logic                tick;
    logic [DIGITS-1:0]   sel_oh;
    logic [3:0]          nib;
    logic                dp_sel;
    logic                blank_sel;
    logic                lz_blank;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    always_comb begin
        tick     = (div_q == DIV_W'(CLK_DIV - 1));
        div_d    = tick ? '0 : div_q + 1'b1;
        idx_d    = idx_q;
        if (tick) begin
            idx_d = (idx_q == 4'(DIGITS - 1)) ? 4'd0 : idx_q + 4'd1;
        end
        shadow_d = (load && !freeze) ? data : shadow_q;
    end

    // Output stage reads the current idx/shadow, so a simultaneous load+tick shows up one edge later.
    always_comb begin
        sel_oh    = DIGITS'(1) << idx_q;
        nib       = 4'(shadow_q >> {idx_q, 2'b00});
        dp_sel    = |(dp & sel_oh);
        blank_sel = |(blank_mask & sel_oh);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        lz_blank  = (idx_q != 4'd0) && ((shadow_q >> {idx_q, 2'b00}) == '0);
`else
        lz_blank  = 1'b0;
`endif
        seg_d     = (blank_sel || lz_blank) ? 8'hFF : {~dp_sel, decode(nib)};
        an_d      = ~sel_oh;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shadow_q <= '0;
            div_q    <= '0;
            idx_q    <= '0;
            seg_q    <= 8'hFF;
            an_q     <= '1;
            sidx_q   <= '0;
        end else begin
            shadow_q <= shadow_d;
            div_q    <= div_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            sidx_q   <= idx_q;
        end
    end

    assign SEG      = seg_q;
    assign AN       = an_q;
    assign scan_idx = sidx_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: three configurations against a cycle-count reference model plus literal checks.
module tb_seg_scan_display;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST;
    logic [31:0] data;
    logic        load, freeze;
    logic [7:0]  dp, blank;

    logic [7:0]  segA, anA;
    logic [3:0]  idxA;
    logic [7:0]  segB;
    logic [3:0]  anB, idxB;
    logic [7:0]  segC;
    logic [0:0]  anC;
    logic [3:0]  idxC;

    seg_scan_display #(.DIGITS(8), .CLK_DIV(3), .DIV_W(4)) dut_a (
        .CLK(CLK), .RST(RST), .data(data), .load(load), .freeze(freeze),
        .dp(dp), .blank_mask(blank), .SEG(segA), .AN(anA), .scan_idx(idxA));

    seg_scan_display #(.DIGITS(4), .CLK_DIV(4), .DIV_W(4)) dut_b (
        .CLK(CLK), .RST(RST), .data(data[15:0]), .load(load), .freeze(freeze),
        .dp(dp[3:0]), .blank_mask(blank[3:0]), .SEG(segB), .AN(anB), .scan_idx(idxB));

    seg_scan_display #(.DIGITS(1), .CLK_DIV(1), .DIV_W(1)) dut_c (
        .CLK(CLK), .RST(RST), .data(data[3:0]), .load(load), .freeze(freeze),
        .dp(dp[0:0]), .blank_mask(blank[0:0]), .SEG(segC), .AN(anC), .scan_idx(idxC));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    logic [7:0] DEC [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Expected outputs after the k-th edge since reset release: digit shown is ((k-1)/cdiv) mod digits.
    function automatic void model(input int digits, input int cdiv, input int k,
                                  input logic [31:0] shd, input logic [7:0] dpv, input logic [7:0] bm,
                                  output logic [7:0] seg, output logic [15:0] an, output logic [3:0] idx);
        int d;
        logic [31:0] m, s;
        logic [3:0] nib;
        logic blk;
        m = (digits >= 8) ? 32'hFFFF_FFFF : ((32'h1 << (4 * digits)) - 32'h1);
        s = shd & m;
        if (k == 0) begin
            seg = 8'hFF;
            an  = 16'((32'h1 << digits) - 32'h1);
            idx = 4'd0;
            return;
        end
        d   = ((k - 1) / cdiv) % digits;
        nib = 4'(s >> (4 * d));
        blk = bm[d];
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (d > 0 && (s >> (4 * d)) == 32'h0) blk = 1'b1;
`endif
        seg = blk ? 8'hFF : {~dpv[d], DEC[nib][6:0]};
        an  = 16'(((32'h1 << digits) - 32'h1) & ~(32'h1 << d));
        idx = 4'(d);
    endfunction

    // Model state: edges since release, live shadow, and the inputs the current output was built from.
    int          kA = 0, kB = 0, kC = 0;
    logic [31:0] sh = 32'h0, used_sh = 32'h0;
    logic [7:0]  used_dp = 8'h0, used_bm = 8'h0;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            kA = 0; kB = 0; kC = 0;
            sh = 32'h0;
        end else begin
            kA++; kB++; kC++;
            used_sh = sh;
            used_dp = dp;
            used_bm = blank;
            if (load && !freeze) sh = data;
        end
    end

    always @(negedge CLK) begin
        logic [7:0]  es;
        logic [15:0] ea;
        logic [3:0]  ei;
        model(8, 3, kA, used_sh, used_dp, used_bm, es, ea, ei);
        chk("A_seg", 32'(segA), 32'(es));
        chk("A_an",  32'(anA),  32'(ea));
        chk("A_idx", 32'(idxA), 32'(ei));
        model(4, 4, kB, used_sh, used_dp, used_bm, es, ea, ei);
        chk("B_seg", 32'(segB), 32'(es));
        chk("B_an",  32'(anB),  32'(ea));
        chk("B_idx", 32'(idxB), 32'(ei));
        model(1, 1, kC, used_sh, used_dp, used_bm, es, ea, ei);
        chk("C_seg", 32'(segC), 32'(es));
        chk("C_an",  32'(anC),  32'(ea));
        chk("C_idx", 32'(idxC), 32'(ei));
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    logic [3:0] an_seq  [5] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
    logic [7:0] lit_dec [8] = '{8'h8E, 8'h86, 8'h21, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
    logic [7:0] lit_frz [8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    logic [7:0] lit_an8 [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [7:0] lit_lz  [8] = '{8'h92, 8'hC0, 8'h88, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`endif

    initial begin
        RST = 1'b0; data = 32'h0; load = 1'b0; freeze = 1'b0; dp = 8'h0; blank = 8'h0;
        repeat (3) step();
        chk("rst_seg", 32'(segA), 32'h0000_00FF);
        chk("rst_an",  32'(anA),  32'h0000_00FF);
        chk("rst_idx", 32'(idxA), 32'h0);
        RST = 1'b1;

        for (int e = 1; e <= 20; e++) begin
            step();
            chk("scan_order_B", 32'(anB), 32'(an_seq[(e - 1) / 4]));
        end

        @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        chk("async_rst_seg", 32'(segA), 32'h0000_00FF);
        chk("async_rst_an",  32'(anA),  32'h0000_00FF);
        chk("async_rst_idx", 32'(idxA), 32'h0);
        step();
        RST = 1'b1;

        data = 32'h89AB_CDEF; dp = 8'h04; load = 1'b1;
        step();
        load = 1'b0;
        step();
        for (int i = 0; i < 24; i++) begin
            chk("decode", 32'(segA), 32'(lit_dec[idxA[2:0]]));
            step();
        end

        dp = 8'h00; data = 32'h1234_5678; load = 1'b1;
        step();
        freeze = 1'b1; data = 32'hFFFF_FFFF;
        step();
        step();
        for (int i = 0; i < 24; i++) begin
            chk("freeze_hold", 32'(segA), 32'(lit_frz[idxA[2:0]]));
            step();
        end
        freeze = 1'b0;
        step();
        load = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            chk("unfreeze_F", 32'(segA), 32'h0000_008E);
            step();
        end

        blank = 8'h0F;
        step();
        for (int i = 0; i < 16; i++) begin
            chk("blank_seg", 32'(segA), (idxA < 4'd4) ? 32'h0000_00FF : 32'h0000_008E);
            chk("blank_an",  32'(anA),  32'(lit_an8[idxA[2:0]]));
            step();
        end
        blank = 8'h00;

        data = 32'hFFFF_FFF5; load = 1'b1;
        step();
        chk("C_old_nibble", 32'(segC), 32'h0000_008E);
        chk("C_an_low",     32'(anC),  32'h0);
        load = 1'b0;
        step();
        chk("C_new_nibble", 32'(segC), 32'h0000_0092);

`ifdef SEG_LEADING_ZERO_BLANK_EN
        data = 32'h0000_0A05; load = 1'b1;
        step();
        load = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            chk("lead_zero", 32'(segA), 32'(lit_lz[idxA[2:0]]));
            step();
        end
`endif

        for (int i = 0; i < 1500; i++) begin
            step();
            data   = $urandom >> (4 * $urandom_range(0, 8));
            load   = ($urandom_range(0, 3) == 0);
            freeze = ($urandom_range(0, 4) == 0);
            dp     = 8'($urandom);
            blank  = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            RST    = ($urandom_range(0, 199) != 0);
        end
        RST = 1'b1;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
